axis_video_pattern_gen: RTL
===========================

Name: axis_video_pattern_gen

Overview:
- AXI4-Stream video source that produces raster frames of IMAGE_WIDTH x IMAGE_HEIGHT 24-bit pixels.
- Frame framing: tuser marks start-of-frame, tlast marks end-of-line.
- It is the transmitter end of the video stream consumed by the ROI masking stage. It acts as bench and bring-up stimulus and as a fallback source when no camera is attached.
- Selectable patterns are solid colour, gradient, checkerboard and colour bars. Programmable line and frame blanking gaps are inserted.

Parameters:
- IMAGE_WIDTH, 640, active pixels per line (>= 8).
- IMAGE_HEIGHT, 480, active lines per frame (>= 2).
- LINE_GAP, 0, idle cycles with tvalid low after each line's tlast handshake (0 = back-to-back).
- FRAME_GAP, 16, idle cycles with tvalid low after the last pixel of a frame.
- CHECK_LOG2, 4, checker square size is 2^CHECK_LOG2 pixels.
- SOLID_RGB, 24'h00FF00, colour for pattern 0.

Ports:
- aclk  input  1  clock; all logic rising-edge.
- aresetn  input  1  synchronous, active-low reset.
- enable  input  1  run request; sampled only at frame boundaries.
- pattern_sel  input  2  0 solid, 1 gradient, 2 checker, 3 colour bars; latched at frame start.
- m_axis_tdata  output  24  pixel, {R[23:16], G[15:8], B[7:0]}.
- m_axis_tvalid  output  1  pixel valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  last pixel of line.
- m_axis_tuser  output  1  first pixel of frame.
- frame_done  output  1  one-cycle pulse on the handshake of the final pixel of a frame.
- frame_cnt  output  16  completed frames; wraps 0xFFFF -> 0.

Behaviour:
- Reset (aresetn=0 at a clock edge): state IDLE, x=y=0, tvalid=0, tdata=0, tlast=0, tuser=0, frame_done=0, frame_cnt=0.
- Reset applied mid-frame abandons the frame immediately. No tlast is emitted for the partial line.
- All outputs are registered. Handshake fires when tvalid && tready.
- AXI-S master rule: once tvalid=1, tdata/tlast/tuser stay stable until the handshake. tvalid never drops without a handshake.
- FSM states:
  - IDLE: tvalid=0. If enable=1, latch pattern_sel, set x=y=0, present pixel (0,0) with tuser=1, go to ACTIVE. The first tvalid appears on the cycle after enable is seen.
  - ACTIVE: on each handshake, advance x. At x=IMAGE_WIDTH-1, x wraps to 0 and y increments.
    - The next pixel is presented on the cycle after the handshake, so full throughput is 1 pixel/clk when tready is held high.
    - tlast=1 exactly when x=IMAGE_WIDTH-1. tuser=1 only at (0,0).
    - After a tlast handshake: if the line was not the last and LINE_GAP>0, go to LGAP. If the line was the last, go to FGAP.
  - LGAP: tvalid=0 for exactly LINE_GAP cycles, then present the next line's x=0 pixel.
  - FGAP: tvalid=0 for exactly FRAME_GAP cycles. If FRAME_GAP=0, the decision is taken in the same cycle. Then:
    - enable=1: relatch pattern_sel and start the next frame (tuser=1).
    - enable=0: go to IDLE.
- Deasserting enable mid-frame has no effect until the frame completes. Frames are never truncated.
- pattern_sel changes mid-frame are ignored until the next frame start.
- frame_done pulses and frame_cnt increments in the cycle after the handshake of pixel (IMAGE_WIDTH-1, IMAGE_HEIGHT-1).
- Pixel generation uses the latched pattern, x and y of the pixel being presented:
  - 0: SOLID_RGB.
  - 1: g = x[7:0]; tdata = {g, g, g}. Wraps every 256 pixels.
  - 2: (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000.
  - 3: bar width BW = IMAGE_WIDTH/8 (integer division). bar = min(x/BW, 7), implemented with a bar sub-counter rather than a divider. The remainder pixels belong to bar 7.
    - Colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Counter widths: $clog2 of the dimension. y resets to 0 at frame start.

Test Plan:
- W=8, H=4, LINE_GAP=0, FRAME_GAP=2, pattern 1, tready=1, enable=1 -> 32 consecutive tvalid cycles. tdata = 000000, 010101 … 070707 per line. tuser only on beat 0. tlast on beats 7, 15, 23, 31. frame_done pulses once, frame_cnt=1. Then exactly 2 tvalid=0 cycles, then the next tuser.
- Same config, pattern 3 -> per line the tdata sequence is FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Random tready backpressure (~40% low) -> no pixel dropped or duplicated. tdata/tlast/tuser are stable while tvalid && !tready. The output stream matches a golden model.
- LINE_GAP=3 -> exactly 3 tvalid=0 cycles after each non-final tlast handshake, and none inside a line when tready=1.
- enable dropped at pixel (3,1), pattern_sel changed 1->2 mid-frame -> the frame completes with gradient data (32 beats), then IDLE with tvalid=0. Re-enabling starts a checker frame with tuser=1 at 000000.
- aresetn low for 1 cycle at pixel (5,2) -> next cycle tvalid=0 and frame_cnt=0. With enable=1, the following frame starts at (0,0) with tuser=1.

Source files
------------

// File: rtl/axis_video_pattern_gen.sv
// axis_video_pattern_gen
//   AXI4-Stream video test-pattern source. Emits IMAGE_WIDTH x IMAGE_HEIGHT
//   frames of 24-bit RGB pixels. tuser marks the first pixel of a frame and
//   tlast marks the last pixel of a line. Idle gaps are inserted after each
//   line (LINE_GAP) and after each frame (FRAME_GAP).
//
// Ports
//   aclk, aresetn   clock, synchronous active-low reset
//   enable          run request, looked at only on frame boundaries
//   pattern_sel     0 solid, 1 gradient, 2 checker, 3 colour bars
//   m_axis_*        AXI4-Stream master (tdata {R,G,B}, tvalid, tready, tlast, tuser)
//   frame_done      one-cycle pulse after the final pixel of a frame is accepted
//   frame_cnt       completed-frame counter (wraps)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no output; waits for enable to start a frame
// ACTIVE  | a pixel is presented; advances on each handshake
// LGAP    | idle cycles between lines
// FGAP    | idle cycles after a frame; then restart or return to IDLE
module axis_video_pattern_gen #(
  parameter int          IMAGE_WIDTH  = 640,
  parameter int          IMAGE_HEIGHT = 480,
  parameter int          LINE_GAP     = 0,
  parameter int          FRAME_GAP    = 16,
  parameter int          CHECK_LOG2   = 4,
  parameter logic [23:0] SOLID_RGB    = 24'h00FF00
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int XW   = $clog2(IMAGE_WIDTH);
  localparam int YW   = $clog2(IMAGE_HEIGHT);
  localparam int BW   = IMAGE_WIDTH / 8;
  localparam int GMAX = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
  localparam int GW   = (GMAX < 2) ? 1 : $clog2(GMAX);

  localparam logic [XW-1:0] X_LAST    = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(IMAGE_HEIGHT - 1);
  localparam logic [XW-1:0] BC_LAST   = XW'(BW - 1);
  localparam logic [GW-1:0] LGAP_LOAD = (LINE_GAP > 0)  ? GW'(LINE_GAP - 1)  : '0;
  localparam logic [GW-1:0] FGAP_LOAD = (FRAME_GAP > 0) ? GW'(FRAME_GAP - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_LGAP, S_FGAP} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [2:0]    bar_q, bar_d;
  logic [XW-1:0] bcnt_q, bcnt_d;
  logic [1:0]    pat_q, pat_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [23:0]   tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;
  logic          tuser_q, tuser_d;
  logic          fdone_q, fdone_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          hs;
  logic          start_frame;

  function automatic logic [23:0] pix_f(input logic [1:0] pat, input logic [XW-1:0] x,
                                        input logic [YW-1:0] y, input logic [2:0] bar);
    logic [7:0] g;
    logic       cx, cy;
    g  = 8'(x);
    cx = 1'(32'(x) >> CHECK_LOG2);
    cy = 1'(32'(y) >> CHECK_LOG2);
    case (pat)
      2'd0:    pix_f = SOLID_RGB;
      2'd1:    pix_f = {g, g, g};
      2'd2:    pix_f = (cx ^ cy) ? 24'hFFFFFF : 24'h000000;
      default: begin
        case (bar)
          3'd0:    pix_f = 24'hFFFFFF;
          3'd1:    pix_f = 24'hFFFF00;
          3'd2:    pix_f = 24'h00FFFF;
          3'd3:    pix_f = 24'h00FF00;
          3'd4:    pix_f = 24'hFF00FF;
          3'd5:    pix_f = 24'hFF0000;
          3'd6:    pix_f = 24'h0000FF;
          default: pix_f = 24'h000000;
        endcase
      end
    endcase
  endfunction

  assign hs = tvalid_q && m_axis_tready;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    bar_d       = bar_q;
    bcnt_d      = bcnt_q;
    pat_d       = pat_q;
    gap_d       = gap_q;
    tvalid_d    = tvalid_q;
    fdone_d     = 1'b0;
    fcnt_d      = fcnt_q;
    start_frame = 1'b0;

    case (state_q)
      S_IDLE: begin
        tvalid_d = 1'b0;
        if (enable) start_frame = 1'b1;
      end
      S_ACTIVE: begin
        if (hs) begin
          if (x_q == X_LAST) begin
            x_d    = '0;
            bar_d  = '0;
            bcnt_d = '0;
            if (y_q == Y_LAST) begin
              y_d      = '0;
              fdone_d  = 1'b1;
              fcnt_d   = fcnt_q + 16'd1;
              tvalid_d = 1'b0;
              if (FRAME_GAP > 0) begin
                state_d = S_FGAP;
                gap_d   = FGAP_LOAD;
              end else if (enable) begin
                start_frame = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              y_d = y_q + 1'b1;
              if (LINE_GAP > 0) begin
                state_d  = S_LGAP;
                gap_d    = LGAP_LOAD;
                tvalid_d = 1'b0;
              end
            end
          end else begin
            x_d = x_q + 1'b1;
            // Bar 7 never advances, so it soaks up the IMAGE_WIDTH % 8 remainder.
            if (bar_q != 3'd7 && bcnt_q == BC_LAST) begin
              bar_d  = bar_q + 3'd1;
              bcnt_d = '0;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
      end
      S_LGAP: begin
        if (gap_q == '0) begin
          state_d  = S_ACTIVE;
          tvalid_d = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_FGAP: begin
        if (gap_q == '0) begin
          if (enable) start_frame = 1'b1;
          else        state_d     = S_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_frame) begin
      state_d  = S_ACTIVE;
      pat_d    = pattern_sel;
      x_d      = '0;
      y_d      = '0;
      bar_d    = '0;
      bcnt_d   = '0;
      tvalid_d = 1'b1;
    end

    // Payload is rebuilt from the held coordinates every cycle, so it is
    // automatically stable while a beat is stalled.
    tdata_d = tvalid_d ? pix_f(pat_d, x_d, y_d, bar_d) : 24'h000000;
    tlast_d = tvalid_d && (x_d == X_LAST);
    tuser_d = tvalid_d && (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      bar_q    <= '0;
      bcnt_q   <= '0;
      pat_q    <= '0;
      gap_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      fdone_q  <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      bar_q    <= bar_d;
      bcnt_q   <= bcnt_d;
      pat_q    <= pat_d;
      gap_q    <= gap_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      fdone_q  <= fdone_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_done    = fdone_q;
  assign frame_cnt     = fcnt_q;

endmodule
